stack_queue: RTL and testbench
==============================

STACK_QUEUE -- requirements
Module: stack_queue

Interface
REQ-001 SHALL take parameter DATA_WIDTH, default 2, width of each stored entry (>=1).
REQ-002 SHALL take parameter DEPTH, default 16, number of entries (>=2, need not be a power of two).
REQ-003 SHALL have port CLK  input  1  sole clock, rising edge.
REQ-004 SHALL have port RST_N  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port PUSH  input  1  write request.
REQ-006 SHALL have port POP  input  1  read/remove request.
REQ-007 SHALL have port MODE  input  1  requested mode: 0=LIFO, 1=FIFO.
REQ-008 SHALL have port DATA_IN  input  DATA_WIDTH  write data.
REQ-009 SHALL have port DATA_OUT  output  DATA_WIDTH  head entry: top in LIFO, oldest in FIFO.
REQ-010 SHALL have port FULL  output  1  COUNT==DEPTH.
REQ-011 SHALL have port EMPTY  output  1  COUNT==0.
REQ-012 SHALL have port COUNT  output  clog2(DEPTH+1)  current occupancy.
REQ-013 SHALL have port MODE_Q  output  1  active mode.
REQ-014 SHALL have port OVERFLOW  output  1  sticky error flag, present only per REQ-031.
REQ-015 SHALL have port UNDERFLOW  output  1  sticky error flag, present only per REQ-031.

Function
REQ-016 DATA_OUT SHALL be combinational from the storage and pointers: valid in the same cycle COUNT>0, and 0 when EMPTY.
REQ-017 PUSH alone, not FULL: SHALL write DATA_IN at the next edge and increment COUNT by 1.
REQ-018 POP alone, not EMPTY: SHALL remove the head entry at the next edge and decrement COUNT by 1.
REQ-019 PUSH when FULL without POP: SHALL be dropped with storage and COUNT unchanged.
REQ-020 POP when EMPTY: SHALL be dropped with storage and COUNT unchanged.
REQ-021 PUSH+POP in LIFO, not EMPTY: SHALL overwrite the top with DATA_IN with COUNT unchanged, including when FULL.
REQ-022 PUSH+POP in FIFO, not EMPTY: SHALL pop the oldest entry and append DATA_IN in the same edge with COUNT unchanged, including when FULL.
REQ-023 PUSH+POP when EMPTY: SHALL act as PUSH alone, giving COUNT=1 with no underflow.
REQ-024 FIFO read and write pointers SHALL wrap from DEPTH-1 to 0 explicitly; modulo-2^n wrap SHALL NOT be relied on.
REQ-025 MODE_Q SHALL load MODE only on an edge where EMPTY=1 and no PUSH is asserted; MODE changes at any other time SHALL be ignored until that condition holds.
REQ-026 A mode switch SHALL reset the internal pointers to 0 and SHALL NOT alter COUNT (already 0).

Reset
REQ-027 RST_N low SHALL immediately force COUNT=0, EMPTY=1, FULL=0, DATA_OUT=0, MODE_Q=0 (LIFO), pointers=0, OVERFLOW=0, UNDERFLOW=0.
REQ-028 Reset asserted mid-operation SHALL discard all contents; storage array contents SHALL NOT require reset.
REQ-029 The first edge after RST_N rises SHALL accept operations normally.

Configuration
REQ-030 Macro STACK_QUEUE_ERR_FLAGS_EN SHALL select whether the error flags are built.
REQ-031 With STACK_QUEUE_ERR_FLAGS_EN defined: OVERFLOW SHALL set on a dropped PUSH (REQ-019) and UNDERFLOW on a dropped POP (REQ-020); both SHALL stay set until reset.
REQ-032 Without STACK_QUEUE_ERR_FLAGS_EN: OVERFLOW and UNDERFLOW SHALL be tied to 0 with no flops; all other behaviour SHALL be identical.

Structure
REQ-033 Package stack_queue_pkg SHALL hold the mode typedef (MODE_LIFO=0, MODE_FIFO=1) and the count-width constant function.
REQ-034 Storage SHALL be a sub-module stack_queue_mem: DEPTH x DATA_WIDTH, one synchronous write port, one combinational read port, no reset.
REQ-035 Control, pointers, COUNT and flags SHALL reside in stack_queue.

Verification (DATA_WIDTH=2, DEPTH=16, macro defined)
REQ-036 LIFO: push 1,2,3 then pop three times -> DATA_OUT 3,2,1, then EMPTY=1 and DATA_OUT=0.
REQ-037 FIFO (MODE=1 while empty): push 1,2,3 then pop three times -> DATA_OUT 1,2,3; the 16-push fill then 16-pop drain wraps the pointers with no data loss.
REQ-038 Push 16 entries -> FULL=1, COUNT=16; a 17th PUSH -> COUNT=16, OVERFLOW=1 and stays 1; POP on empty -> UNDERFLOW=1.
REQ-039 Simultaneous events: LIFO full, PUSH+POP with 2 -> top=2, COUNT=16; FIFO empty, PUSH+POP with 3 -> COUNT=1, DATA_OUT=3, UNDERFLOW=0.
REQ-040 MODE toggled with COUNT=5 -> MODE_Q unchanged; after draining to empty, MODE_Q follows MODE next edge.
REQ-041 RST_N pulsed low mid-stream with COUNT=7 -> COUNT=0, EMPTY=1, flags 0, all asynchronously before the next edge.

Source files
------------

// File: rtl/stack_queue_pkg.sv
// rtl/stack_queue_pkg.sv - shared mode type and occupancy width helper for stack_queue
package stack_queue_pkg;

  typedef enum logic {
    MODE_LIFO = 1'b0,
    MODE_FIFO = 1'b1
  } mode_t;

  // COUNT must represent 0..DEPTH inclusive
  function automatic int count_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/stack_queue_mem.sv
// rtl/stack_queue_mem.sv - DEPTH x DATA_WIDTH storage, sync write, async read, no reset
module stack_queue_mem #(
  parameter int DATA_WIDTH = 2,
  parameter int DEPTH      = 16,
  parameter int ADDR_W     = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_W-1:0]     waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_W-1:0]     raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/stack_queue.sv
// rtl/stack_queue.sv - LIFO/FIFO switchable queue; STACK_QUEUE_ERR_FLAGS_EN builds sticky OVERFLOW/UNDERFLOW
module stack_queue
  import stack_queue_pkg::*;
#(
  parameter int DATA_WIDTH = 2,
  parameter int DEPTH      = 16
) (
  input  logic                          CLK,
  input  logic                          RST_N,
  input  logic                          PUSH,
  input  logic                          POP,
  input  logic                          MODE,
  input  logic [DATA_WIDTH-1:0]         DATA_IN,
  output logic [DATA_WIDTH-1:0]         DATA_OUT,
  output logic                          FULL,
  output logic                          EMPTY,
  output logic [count_width(DEPTH)-1:0] COUNT,
  output logic                          MODE_Q,
  output logic                          OVERFLOW,
  output logic                          UNDERFLOW
);

  localparam int ADDR_W = $clog2(DEPTH);
  localparam int CNT_W  = count_width(DEPTH);

  logic [CNT_W-1:0]      count;
  logic [ADDR_W-1:0]     rd_ptr;
  logic [ADDR_W-1:0]     wr_ptr;
  mode_t                 mode_q;

  logic                  is_empty;
  logic                  is_full;
  logic                  both_op;
  logic                  push_only;
  logic                  pop_only;
  logic                  mode_load;
  logic [ADDR_W-1:0]     top_idx;
  logic                  mem_we;
  logic [ADDR_W-1:0]     mem_waddr;
  logic [ADDR_W-1:0]     mem_raddr;
  logic [DATA_WIDTH-1:0] mem_rdata;

  // DEPTH need not be a power of two, so wrap is an explicit compare
  function automatic logic [ADDR_W-1:0] next_ptr(input logic [ADDR_W-1:0] p);
    return (p == ADDR_W'(DEPTH - 1)) ? '0 : p + ADDR_W'(1);
  endfunction

  assign is_empty  = (count == '0);
  assign is_full   = (count == CNT_W'(DEPTH));
  assign both_op   = PUSH && POP && !is_empty;
  assign push_only = PUSH && !both_op && !is_full;
  assign pop_only  = POP && !PUSH && !is_empty;
  assign mode_load = is_empty && !PUSH;
  assign top_idx   = ADDR_W'(count - CNT_W'(1));

  // LIFO uses the occupancy as its stack pointer; FIFO uses the ring pointers
  assign mem_we    = both_op || push_only;
  assign mem_waddr = (mode_q == MODE_FIFO) ? wr_ptr
                   : (both_op ? top_idx : ADDR_W'(count));
  assign mem_raddr = (mode_q == MODE_FIFO) ? rd_ptr
                   : (is_empty ? '0 : top_idx);

  stack_queue_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .ADDR_W     (ADDR_W)
  ) u_mem (
    .clk   (CLK),
    .we    (mem_we),
    .waddr (mem_waddr),
    .wdata (DATA_IN),
    .raddr (mem_raddr),
    .rdata (mem_rdata)
  );

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      mode_q <= MODE_LIFO;
    end else begin
      if (push_only) begin
        count <= count + CNT_W'(1);
      end else if (pop_only) begin
        count <= count - CNT_W'(1);
      end
      if (mode_load) begin
        mode_q <= mode_t'(MODE);
        rd_ptr <= '0;
        wr_ptr <= '0;
      end else if (mode_q == MODE_FIFO) begin
        if (mem_we) begin
          wr_ptr <= next_ptr(wr_ptr);
        end
        if (both_op || pop_only) begin
          rd_ptr <= next_ptr(rd_ptr);
        end
      end
    end
  end

  assign DATA_OUT = is_empty ? '0 : mem_rdata;
  assign FULL     = is_full;
  assign EMPTY    = is_empty;
  assign COUNT    = count;
  assign MODE_Q   = mode_q;

`ifdef STACK_QUEUE_ERR_FLAGS_EN
  logic drop_push;
  logic drop_pop;
  logic ovf_q;
  logic udf_q;

  assign drop_push = PUSH && !POP && is_full;
  assign drop_pop  = POP && !PUSH && is_empty;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      if (drop_push) begin
        ovf_q <= 1'b1;
      end
      if (drop_pop) begin
        udf_q <= 1'b1;
      end
    end
  end

  assign OVERFLOW  = ovf_q;
  assign UNDERFLOW = udf_q;
`else
  assign OVERFLOW  = 1'b0;
  assign UNDERFLOW = 1'b0;
`endif

endmodule

// File: tb/tb_stack_queue.sv
// tb/tb_stack_queue.sv - randomized scoreboard bench for stack_queue against a queue-based model
module tb_stack_queue;

  localparam int DW    = 2;
  localparam int DEPTH = 16;
  localparam int CW    = $clog2(DEPTH + 1);

  logic          clk   = 1'b0;
  logic          rst_n = 1'b0;
  logic          push  = 1'b0;
  logic          pop   = 1'b0;
  logic          mode  = 1'b0;
  logic [DW-1:0] din   = '0;
  logic [DW-1:0] dout;
  logic          full;
  logic          empty;
  logic [CW-1:0] count;
  logic          mode_q;
  logic          ovf;
  logic          udf;

  always #5 clk = ~clk;

  stack_queue #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .CLK       (clk),
    .RST_N     (rst_n),
    .PUSH      (push),
    .POP       (pop),
    .MODE      (mode),
    .DATA_IN   (din),
    .DATA_OUT  (dout),
    .FULL      (full),
    .EMPTY     (empty),
    .COUNT     (count),
    .MODE_Q    (mode_q),
    .OVERFLOW  (ovf),
    .UNDERFLOW (udf)
  );

  typedef struct {
    int count;
    int data;
    int empty;
    int full;
    int mode;
    int ovf;
    int udf;
  } exp_t;

  exp_t exp_q[$];
  int   model[$];
  int   m_mode = 0;
  int   m_ovf  = 0;
  int   m_udf  = 0;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cur_mode = 0;

  task automatic check(input string name, input logic [31:0] act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_t snapshot();
    exp_t e;
    e.count = model.size();
    e.empty = (model.size() == 0);
    e.full  = (model.size() == DEPTH);
    e.data  = (model.size() == 0) ? 0 : ((m_mode == 1) ? model[0] : model[model.size()-1]);
    e.mode  = m_mode;
`ifdef STACK_QUEUE_ERR_FLAGS_EN
    e.ovf   = m_ovf;
    e.udf   = m_udf;
`else
    e.ovf   = 0;
    e.udf   = 0;
`endif
    return e;
  endfunction

  function automatic void model_apply(input bit p, input bit q, input bit md, input int d);
    bit was_empty;
    bit was_full;
    was_empty = (model.size() == 0);
    was_full  = (model.size() == DEPTH);
    if (p && q && !was_empty) begin
      if (m_mode == 0) model[model.size()-1] = d;
      else begin
        void'(model.pop_front());
        model.push_back(d);
      end
    end else if (p) begin
      if (!was_full) model.push_back(d);
      else m_ovf = 1;
    end else if (q) begin
      if (!was_empty) begin
        if (m_mode == 0) void'(model.pop_back());
        else void'(model.pop_front());
      end else m_udf = 1;
    end
    if (was_empty && !p) m_mode = md;
  endfunction

  task automatic step(input bit p, input bit q, input int d);
    @(negedge clk);
    push = p;
    pop  = q;
    mode = cur_mode[0];
    din  = d[DW-1:0];
    model_apply(p, q, cur_mode[0], d);
    exp_q.push_back(snapshot());
  endtask

  task automatic check_reset_now(input string tag);
    check({tag, "_count"}, 32'(count), 0);
    check({tag, "_empty"}, 32'(empty), 1);
    check({tag, "_full"},  32'(full), 0);
    check({tag, "_dout"},  32'(dout), 0);
    check({tag, "_mode"},  32'(mode_q), 0);
    check({tag, "_ovf"},   32'(ovf), 0);
    check({tag, "_udf"},   32'(udf), 0);
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst_n = 1'b1;
    push  = 1'b0;
    pop   = 1'b0;
    mode  = 1'b0;
    cur_mode = 0;
    model_apply(1'b0, 1'b0, 1'b0, 0);
    exp_q.push_back(snapshot());
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst_n = 1'b0;
    push  = 1'b0;
    pop   = 1'b0;
    #1;
    check_reset_now("async_reset");
    model.delete();
    m_mode = 0;
    m_ovf  = 0;
    m_udf  = 0;
    exp_q.push_back(snapshot());
    release_reset();
  endtask

  // Monitor: every cycle with a pending expectation is compared after the edge settles
  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (exp_q.size() > 0) begin
        exp_t e;
        e = exp_q.pop_front();
        check("count",    32'(count),  e.count);
        check("data_out", 32'(dout),   e.data);
        check("empty",    32'(empty),  e.empty);
        check("full",     32'(full),   e.full);
        check("mode_q",   32'(mode_q), e.mode);
        check("overflow", 32'(ovf),    e.ovf);
        check("underflow",32'(udf),    e.udf);
      end
    end
  end

  initial begin
    #1;
    check_reset_now("power_on_reset");
    release_reset();

    // LIFO order, then back to empty
    for (int i = 1; i <= 3; i++) step(1, 0, i);
    for (int i = 0; i < 4; i++) step(0, 1, 0);

    // LIFO full, simultaneous push+pop overwrites top
    for (int i = 0; i < DEPTH; i++) step(1, 0, $urandom_range(0, 3));
    step(1, 1, 2);
    for (int i = 0; i < DEPTH; i++) step(0, 1, 0);

    // switch to FIFO while empty; push+pop on empty acts as push
    cur_mode = 1;
    step(0, 0, 0);
    step(1, 1, 3);
    step(0, 1, 0);

    // FIFO order, then fill/drain across the pointer wrap with overflow/underflow
    for (int i = 1; i <= 3; i++) step(1, 0, i);
    for (int i = 0; i < 3; i++) step(0, 1, 0);
    for (int i = 0; i < DEPTH; i++) step(1, 0, $urandom_range(0, 3));
    step(1, 0, 1);
    step(1, 1, 2);
    step(1, 0, 3);
    for (int i = 0; i < DEPTH; i++) step(0, 1, 0);
    step(0, 1, 0);
    step(0, 0, 0);

    // mode change requested while occupied is deferred until empty
    for (int i = 0; i < 5; i++) step(1, 0, $urandom_range(0, 3));
    cur_mode = 0;
    step(0, 0, 0);
    for (int i = 0; i < 5; i++) step(0, 1, 0);
    step(0, 0, 0);
    step(0, 0, 0);

    // reset mid-stream with 7 entries
    for (int i = 0; i < 7; i++) step(1, 0, $urandom_range(0, 3));
    pulse_reset();

    // random traffic with occasional mode requests and one reset
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 15) == 0) cur_mode = 1 - cur_mode;
      if (i == 300) pulse_reset();
      step($urandom_range(0, 99) < 55, $urandom_range(0, 99) < 45, $urandom_range(0, 3));
    end

    @(negedge clk);
    push = 1'b0;
    pop  = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    check("scoreboard_drained", 32'(exp_q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
